// File: rtl/shot_scoreboard.sv
// shot_scoreboard
// Game-state keeper between trajectory_calc and the output mux. It turns the
// raw start/shoot levels into edges, issues single-cycle fire pulses, tracks
// the shot budget, and accumulates score, hit streak and game-over status.
// A shot that gets no result_valid within TIMEOUT_CYC cycles is scored as a
// miss and raises a sticky per-game timeout flag.
module shot_scoreboard #(
    parameter int SHOTS_PER_GAME = 8,
    parameter int SCORE_W        = 5,
    parameter int TIMEOUT_CYC    = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_new_game,
    input  logic               shoot,
    input  logic               result_valid,
    input  logic               hit,
    output logic               shot_fire,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] streak,
    output logic [3:0]         shots_left,
    output logic               in_flight,
    output logic               game_over,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READY  = 2'd1,
        ST_FLIGHT = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    localparam logic [3:0]         SHOTS_V   = 4'(SHOTS_PER_GAME);
    localparam logic [7:0]         TIMEOUT_V = 8'(TIMEOUT_CYC);
    localparam logic [SCORE_W-1:0] ZERO_S    = {SCORE_W{1'b0}};
    localparam logic [SCORE_W-1:0] ONE_S     = {{(SCORE_W-1){1'b0}}, 1'b1};
    localparam logic [SCORE_W-1:0] MAX_S     = {SCORE_W{1'b1}};

    // Saturating increment used for both score and streak.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        if (v == MAX_S) begin
            r = v;
        end else begin
            r = v + ONE_S;
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic               shoot_q, shoot_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] streak_q, streak_d;
    logic [3:0]         shots_left_q, shots_left_d;
    logic               in_flight_q, in_flight_d;
    logic               game_over_q, game_over_d;
    logic               timeout_err_q, timeout_err_d;
    logic               shot_fire_q, shot_fire_d;
    logic [7:0]         timer_q, timer_d;

    logic               start_edge_s;
    logic               shoot_edge_s;
    logic               resolve_s;

    assign start_edge_s = start_new_game & ~start_q;
    assign shoot_edge_s = shoot & ~shoot_q;

    // Next-state and next-output computation; start edge overrides everything.
    always_comb begin
        state_d       = state_q;
        start_d       = start_new_game;
        shoot_d       = shoot;
        score_d       = score_q;
        streak_d      = streak_q;
        shots_left_d  = shots_left_q;
        in_flight_d   = in_flight_q;
        game_over_d   = game_over_q;
        timeout_err_d = timeout_err_q;
        shot_fire_d   = 1'b0;
        timer_d       = timer_q;
        resolve_s     = 1'b0;

        if (start_edge_s) begin
            state_d       = ST_READY;
            score_d       = ZERO_S;
            streak_d      = ZERO_S;
            shots_left_d  = SHOTS_V;
            in_flight_d   = 1'b0;
            game_over_d   = 1'b0;
            timeout_err_d = 1'b0;
            timer_d       = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_READY: begin
                    if (shots_left_q == 4'd0) begin
                        // Empty budget while ready cannot normally occur; close the game.
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                    end else if (shoot_edge_s) begin
                        state_d      = ST_FLIGHT;
                        shot_fire_d  = 1'b1;
                        shots_left_d = shots_left_q - 4'd1;
                        in_flight_d  = 1'b1;
                        timer_d      = 8'd0;
                    end else begin
                        state_d = ST_READY;
                    end
                end
                ST_FLIGHT: begin
                    if (result_valid) begin
                        // A real result beats a timeout landing on the same cycle.
                        resolve_s = 1'b1;
                        if (hit) begin
                            score_d  = sat_inc(score_q);
                            streak_d = sat_inc(streak_q);
                        end else begin
                            streak_d = ZERO_S;
                        end
                    end else if (timer_q == TIMEOUT_V) begin
                        resolve_s     = 1'b1;
                        streak_d      = ZERO_S;
                        timeout_err_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end

                    if (resolve_s) begin
                        in_flight_d = 1'b0;
                        if (shots_left_q == 4'd0) begin
                            state_d     = ST_OVER;
                            game_over_d = 1'b1;
                        end else begin
                            state_d = ST_READY;
                        end
                    end else begin
                        state_d = ST_FLIGHT;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, edge-detect and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            shoot_q       <= 1'b0;
            score_q       <= ZERO_S;
            streak_q      <= ZERO_S;
            shots_left_q  <= 4'd0;
            in_flight_q   <= 1'b0;
            game_over_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            shot_fire_q   <= 1'b0;
            timer_q       <= 8'd0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            shoot_q       <= shoot_d;
            score_q       <= score_d;
            streak_q      <= streak_d;
            shots_left_q  <= shots_left_d;
            in_flight_q   <= in_flight_d;
            game_over_q   <= game_over_d;
            timeout_err_q <= timeout_err_d;
            shot_fire_q   <= shot_fire_d;
            timer_q       <= timer_d;
        end
    end

    assign shot_fire   = shot_fire_q;
    assign score       = score_q;
    assign streak      = streak_q;
    assign shots_left  = shots_left_q;
    assign in_flight   = in_flight_q;
    assign game_over   = game_over_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_shot_scoreboard.sv
// Bench for shot_scoreboard: two instances share the same stimulus, one with a
// 3-shot / 5-bit configuration and one with an 8-shot / 2-bit configuration.
// Both are compared every cycle against a behavioural game model; instance A
// is also checked against a directed table and hand-written corner sequences.
module tb_shot_scoreboard;

    localparam int TO = 31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_new_game = 1'b0;
    logic shoot = 1'b0;
    logic result_valid = 1'b0;
    logic hit = 1'b0;

    logic       a_fire, a_infl, a_over, a_terr;
    logic [4:0] a_score, a_streak;
    logic [3:0] a_left;
    logic       b_fire, b_infl, b_over, b_terr;
    logic [1:0] b_score, b_streak;
    logic [3:0] b_left;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    shot_scoreboard #(.SHOTS_PER_GAME(3), .SCORE_W(5), .TIMEOUT_CYC(TO)) u_a (
        .clk(clk), .rst_n(rst_n), .start_new_game(start_new_game), .shoot(shoot),
        .result_valid(result_valid), .hit(hit), .shot_fire(a_fire), .score(a_score),
        .streak(a_streak), .shots_left(a_left), .in_flight(a_infl),
        .game_over(a_over), .timeout_err(a_terr)
    );

    shot_scoreboard #(.SHOTS_PER_GAME(8), .SCORE_W(2), .TIMEOUT_CYC(TO)) u_b (
        .clk(clk), .rst_n(rst_n), .start_new_game(start_new_game), .shoot(shoot),
        .result_valid(result_valid), .hit(hit), .shot_fire(b_fire), .score(b_score),
        .streak(b_streak), .shots_left(b_left), .in_flight(b_infl),
        .game_over(b_over), .timeout_err(b_terr)
    );

    // ---------------- behavioural model ----------------
    int cfg_shots [2] = '{3, 8};
    int cfg_max   [2] = '{31, 3};

    bit m_playing [2];   // a game has been started and is not over
    bit m_fire    [2];
    bit m_flight  [2];
    bit m_over    [2];
    bit m_terr    [2];
    int m_score   [2];
    int m_streak  [2];
    int m_left    [2];
    int m_wait    [2];   // cycles spent waiting for the current result
    bit m_pstart;
    bit m_pshoot;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_playing[i] = 0; m_fire[i] = 0; m_flight[i] = 0; m_over[i] = 0;
            m_terr[i] = 0; m_score[i] = 0; m_streak[i] = 0; m_left[i] = 0; m_wait[i] = 0;
        end
        m_pstart = 0;
        m_pshoot = 0;
    endtask

    task automatic model_step();
        bit se, sh, done;
        se = start_new_game && !m_pstart;
        sh = shoot && !m_pshoot;
        m_pstart = start_new_game;
        m_pshoot = shoot;
        for (int i = 0; i < 2; i++) begin
            m_fire[i] = 0;
            if (se) begin
                m_playing[i] = 1; m_over[i] = 0; m_flight[i] = 0; m_terr[i] = 0;
                m_score[i] = 0; m_streak[i] = 0; m_left[i] = cfg_shots[i]; m_wait[i] = 0;
            end else if (m_playing[i] && !m_flight[i]) begin
                if (m_left[i] == 0) begin
                    m_over[i] = 1; m_playing[i] = 0;
                end else if (sh) begin
                    m_fire[i] = 1; m_left[i]--; m_flight[i] = 1; m_wait[i] = 0;
                end
            end else if (m_playing[i] && m_flight[i]) begin
                m_wait[i]++;
                done = 0;
                if (result_valid) begin
                    done = 1;
                    if (hit) begin
                        if (m_score[i] < cfg_max[i]) m_score[i]++;
                        if (m_streak[i] < cfg_max[i]) m_streak[i]++;
                    end else begin
                        m_streak[i] = 0;
                    end
                end else if (m_wait[i] > TO) begin
                    done = 1; m_streak[i] = 0; m_terr[i] = 1;
                end
                if (done) begin
                    m_flight[i] = 0;
                    if (m_left[i] == 0) begin
                        m_over[i] = 1; m_playing[i] = 0;
                    end
                end
            end
        end
    endtask

    // ---------------- checks ----------------
    task automatic check_model(input string tag);
        logic [17:0] ga, ea;
        logic [12:0] gb, eb;
        ga = {a_fire, a_infl, a_over, a_terr, a_left, a_score, a_streak};
        ea = {m_fire[0], m_flight[0], m_over[0], m_terr[0], 4'(m_left[0]), 5'(m_score[0]), 5'(m_streak[0])};
        gb = {b_fire, b_infl, b_over, b_terr, b_left, b_score, b_streak};
        eb = {m_fire[1], m_flight[1], m_over[1], m_terr[1], 4'(m_left[1]), 2'(m_score[1]), 2'(m_streak[1])};
        vec_cnt += 2;
        if (ga !== ea) begin
            err_cnt++;
            $display("FAIL %s dutA fire/infl/over/terr/left/score/streak got=%h exp=%h", tag, ga, ea);
        end
        if (gb !== eb) begin
            err_cnt++;
            $display("FAIL %s dutB fire/infl/over/terr/left/score/streak got=%h exp=%h", tag, gb, eb);
        end
    endtask

    task automatic expect_a(input string tag, input int left, input int sc, input int stk,
                            input bit fire, input bit infl, input bit over, input bit terr);
        logic [17:0] g, e;
        g = {a_fire, a_infl, a_over, a_terr, a_left, a_score, a_streak};
        e = {fire, infl, over, terr, 4'(left), 5'(sc), 5'(stk)};
        vec_cnt++;
        if (g !== e) begin
            err_cnt++;
            $display("FAIL %s directedA got=%h exp=%h", tag, g, e);
        end
    endtask

    task automatic expect_b(input string tag, input int sc, input int stk);
        vec_cnt++;
        if (b_score !== 2'(sc) || b_streak !== 2'(stk)) begin
            err_cnt++;
            $display("FAIL %s directedB score/streak got=%0d/%0d exp=%0d/%0d", tag, b_score, b_streak, sc, stk);
        end
    endtask

    task automatic cyc(input bit s, input bit sh, input bit rv, input bit h, input string tag);
        start_new_game = s; shoot = sh; result_valid = rv; hit = h;
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    typedef struct {
        bit s; bit sh; bit rv; bit h;
        int left; int score; int streak;
        bit fire; bit infl; bit over;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{1,0,0,0, 3,0,0, 0,0,0};
        tbl[1]  = '{1,0,0,0, 3,0,0, 0,0,0};
        tbl[2]  = '{0,0,0,0, 3,0,0, 0,0,0};
        tbl[3]  = '{0,1,0,0, 2,0,0, 1,1,0};
        tbl[4]  = '{0,1,0,0, 2,0,0, 0,1,0};
        tbl[5]  = '{0,1,1,1, 2,1,1, 0,0,0};
        tbl[6]  = '{0,0,0,0, 2,1,1, 0,0,0};
        tbl[7]  = '{0,1,0,0, 1,1,1, 1,1,0};
        tbl[8]  = '{0,0,1,1, 1,2,2, 0,0,0};
        tbl[9]  = '{0,1,0,0, 0,2,2, 1,1,0};
        tbl[10] = '{0,0,1,0, 0,2,0, 0,0,1};
        tbl[11] = '{0,1,1,1, 0,2,0, 0,0,1};
        tbl[12] = '{1,0,0,0, 3,0,0, 0,0,0};
        tbl[13] = '{0,0,0,0, 3,0,0, 0,0,0};
        tbl[14] = '{0,1,0,0, 2,0,0, 1,1,0};
        tbl[15] = '{1,0,1,1, 3,0,0, 0,0,0};

        // Reset state.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_a("reset", 0, 0, 0, 0, 0, 0, 0);
        check_model("reset");
        rst_n = 1'b1;

        // Result in IDLE is ignored.
        cyc(0, 0, 1, 1, "idle_rv");
        expect_a("idle_rv", 0, 0, 0, 0, 0, 0, 0);

        // Directed table: start, fire, hit/hit/miss game, over, restart, start beats result.
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].s, tbl[i].sh, tbl[i].rv, tbl[i].h, $sformatf("tbl%0d", i));
            expect_a($sformatf("tbl%0d", i), tbl[i].left, tbl[i].score, tbl[i].streak,
                     tbl[i].fire, tbl[i].infl, tbl[i].over, 1'b0);
        end

        // Holding shoot fires once, then the shot times out.
        cyc(0, 0, 0, 0, "hold_pre");
        cyc(0, 1, 0, 0, "hold_fire");
        expect_a("hold_fire", 2, 0, 0, 1, 1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 1, 0, 0, "hold");
            expect_a($sformatf("hold%0d", k), 2, 0, 0, 0, 1, 0, 0);
        end
        for (int k = 11; k <= TO; k++) cyc(0, 1, 0, 0, "wait");
        expect_a("pre_timeout", 2, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, "timeout");
        expect_a("timeout", 2, 0, 0, 0, 0, 0, 1);

        // Result arriving on the timeout cycle is counted with no error.
        cyc(1, 0, 0, 0, "ng2");
        expect_a("ng2", 3, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, "ng2_idle");
        cyc(0, 1, 0, 0, "ng2_fire");
        for (int k = 1; k <= TO; k++) cyc(0, 0, 0, 0, "wait2");
        cyc(0, 0, 1, 1, "rv_on_timeout");
        expect_a("rv_on_timeout", 2, 1, 1, 0, 0, 0, 0);

        // Saturation of the 2-bit instance after five hits.
        cyc(1, 0, 0, 0, "ng3");
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 0, 0, "sat_fire");
            cyc(0, 0, 1, 1, "sat_hit");
        end
        expect_b("sat", 3, 3);
        expect_a("sat_a", 0, 3, 3, 0, 0, 1, 0);

        // Asynchronous reset mid-flight.
        cyc(0, 0, 0, 0, "ng4_pre");
        cyc(1, 0, 0, 0, "ng4");
        cyc(0, 1, 0, 0, "ng4_fire");
        expect_a("ng4_fire", 2, 0, 0, 1, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        expect_a("async_rst", 0, 0, 0, 0, 0, 0, 0);
        check_model("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 1, 1, 1, "post_rst");
        expect_a("post_rst", 0, 0, 0, 0, 0, 0, 0);

        // Randomized play against the model.
        for (int n = 0; n < 4000; n++) begin
            bit s, sh, rv, h;
            s  = ($urandom_range(0, 39) == 0);
            sh = ($urandom_range(0, 3) == 0) ? !shoot : shoot;
            rv = ($urandom_range(0, 9) == 0);
            h  = 1'($urandom_range(0, 1));
            cyc(s, sh, rv, h, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
